// File: rtl/gate_vector_sequencer.sv
// gate_vector_sequencer
//   Drives the four input combinations {a,b} = 00, 01, 10, 11 into a 2-input
//   AND gate, holds each one for a programmable number of cycles, samples the
//   gate output on the last cycle of each hold and counts mismatches against
//   a&b. At the end of the run it pulses done and reports pass/fail.
//
// Ports:
//   clk     in   rising-edge clock
//   rst     in   synchronous active-high reset, priority over all inputs
//   start   in   run request, accepted only while idle
//   dwell   in   cycles each vector is held (0 behaves as 1), latched at start
//   c       in   output of the gate under test
//   a, b    out  gate inputs (registered)
//   vec_idx out  index of the applied vector, equal to {a,b} while running
//   busy    out  high while the vectors are being applied
//   done    out  one-cycle pulse when a run completes
//   pass    out  last completed run had no mismatches; held until next start
//   err_cnt out  saturating mismatch count of the current or last run
module gate_vector_sequencer #(
    parameter int DWELL_W = 8,
    parameter int ERR_W   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               c,
    output logic               a,
    output logic               b,
    output logic [1:0]         vec_idx,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERR_W-1:0]   err_cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [ERR_W-1:0]   ERR_ZERO  = {ERR_W{1'b0}};
    localparam logic [ERR_W-1:0]   ERR_ONE   = ERR_W'(1);
    localparam logic [ERR_W-1:0]   ERR_MAX   = {ERR_W{1'b1}};
    localparam logic [DWELL_W-1:0] DWELL_ZERO = {DWELL_W{1'b0}};
    localparam logic [DWELL_W-1:0] DWELL_ONE  = DWELL_W'(1);

    logic [1:0]         state_r;
    logic [DWELL_W-1:0] dwell_r;
    logic [DWELL_W-1:0] cnt_r;
    logic               a_r;
    logic               b_r;
    logic [1:0]         vec_idx_r;
    logic               busy_r;
    logic               done_r;
    logic               pass_r;
    logic [ERR_W-1:0]   err_cnt_r;

    logic [DWELL_W-1:0] dwell_eff_s;
    logic               sample_s;
    logic               mismatch_s;
    logic [ERR_W-1:0]   err_next_s;
    logic [1:0]         vec_next_s;

    // Sample-edge detection, mismatch evaluation and saturating count update.
    always_comb begin
        dwell_eff_s = DWELL_ONE;
        if (dwell != DWELL_ZERO) begin
            dwell_eff_s = dwell;
        end else begin
            dwell_eff_s = DWELL_ONE;
        end
        // Last cycle of the current vector's hold.
        sample_s   = (cnt_r == (dwell_r - DWELL_ONE));
        mismatch_s = (c != (a_r & b_r));
        err_next_s = err_cnt_r;
        if (mismatch_s && (err_cnt_r != ERR_MAX)) begin
            err_next_s = err_cnt_r + ERR_ONE;
        end else begin
            err_next_s = err_cnt_r;
        end
        vec_next_s = vec_idx_r + 2'd1;
    end

    // Sequencer state machine with all outputs held in registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            dwell_r   <= DWELL_ONE;
            cnt_r     <= DWELL_ZERO;
            a_r       <= 1'b0;
            b_r       <= 1'b0;
            vec_idx_r <= 2'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            pass_r    <= 1'b0;
            err_cnt_r <= ERR_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        dwell_r   <= dwell_eff_s;
                        cnt_r     <= DWELL_ZERO;
                        a_r       <= 1'b0;
                        b_r       <= 1'b0;
                        vec_idx_r <= 2'd0;
                        err_cnt_r <= ERR_ZERO;
                        pass_r    <= 1'b0;
                        busy_r    <= 1'b1;
                        state_r   <= ST_RUN;
                    end else begin
                        // err_cnt and pass keep the last run's result.
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (sample_s) begin
                        err_cnt_r <= err_next_s;
                        if (vec_idx_r == 2'd3) begin
                            a_r       <= 1'b0;
                            b_r       <= 1'b0;
                            vec_idx_r <= 2'd0;
                            busy_r    <= 1'b0;
                            done_r    <= 1'b1;
                            // Include the final vector's result in the verdict.
                            pass_r    <= (err_next_s == ERR_ZERO);
                            state_r   <= ST_DONE;
                        end else begin
                            vec_idx_r <= vec_next_s;
                            a_r       <= vec_next_s[1];
                            b_r       <= vec_next_s[0];
                            cnt_r     <= DWELL_ZERO;
                        end
                    end else begin
                        cnt_r <= cnt_r + DWELL_ONE;
                    end
                end
                ST_DONE: begin
                    // start is deliberately not looked at here.
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    a_r       <= 1'b0;
                    b_r       <= 1'b0;
                    vec_idx_r <= 2'd0;
                    busy_r    <= 1'b0;
                    done_r    <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    assign a       = a_r;
    assign b       = b_r;
    assign vec_idx = vec_idx_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign pass    = pass_r;
    assign err_cnt = err_cnt_r;

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// Bench for gate_vector_sequencer: a 3-bit counter instance driven by a
// modelled gate (correct, stuck-at-0, stuck-at-1 or inverted, optionally with
// random glitches off the sample edges) and a 1-bit counter instance wired to
// an inverting gate. Expected outputs come from cycle arithmetic relative to
// the accepted start edge.
module tb_gate_vector_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, c;
    logic [7:0] dwell;
    logic       a, b, busy, done, pass;
    logic [1:0] vec_idx;
    logic [2:0] err_cnt;
    logic       a1, b1, busy1, done1, pass1, c1;
    logic [1:0] vec1;
    logic [0:0] err1;
    int checks = 0;
    int errors = 0;

    gate_vector_sequencer #(.DWELL_W(8), .ERR_W(3)) dut (
        .clk(clk), .rst(rst), .start(start), .dwell(dwell), .c(c),
        .a(a), .b(b), .vec_idx(vec_idx), .busy(busy), .done(done),
        .pass(pass), .err_cnt(err_cnt)
    );

    gate_vector_sequencer #(.DWELL_W(8), .ERR_W(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .dwell(dwell), .c(c1),
        .a(a1), .b(b1), .vec_idx(vec1), .busy(busy1), .done(done1),
        .pass(pass1), .err_cnt(err1)
    );

    // Inverted gate: every vector mismatches.
    assign c1 = ~(a1 & b1);

    // Gate output for vector k under fault mode: 0 AND, 1 stuck-0, 2 stuck-1, 3 NAND.
    function automatic logic gate_out(int mode, int k);
        case (mode)
            0:       return (k == 3);
            1:       return 1'b0;
            2:       return 1'b1;
            default: return (k != 3);
        endcase
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(string tag);
        chk({tag, ".a"}, 32'(a), 0);
        chk({tag, ".b"}, 32'(b), 0);
        chk({tag, ".vec_idx"}, 32'(vec_idx), 0);
        chk({tag, ".busy"}, 32'(busy), 0);
        chk({tag, ".done"}, 32'(done), 0);
        chk({tag, ".pass"}, 32'(pass), 0);
        chk({tag, ".err_cnt"}, 32'(err_cnt), 0);
    endtask

    // One run from an accepted start. abort_t: edge index (from start) at which
    // rst is applied, or -1. extra_start: pulse start during vector 1 and in DONE.
    task automatic run(string tag, int dw, int mode, bit glitch, int abort_t,
                       bit extra_start, bit chk1);
        int d, n, vec, nxt;
        d = (dw == 0) ? 1 : dw;
        dwell = dw[7:0];
        start = 1'b1;
        c = 1'($urandom);
        tick();
        start = 1'b0;
        dwell = 8'($urandom);       // must not affect the latched run
        for (int t = 0; t <= 4 * d + 1; t++) begin
            n = 0;
            for (int k = 0; k < 4; k++) begin
                if ((k + 1) * d <= t && gate_out(mode, k) != (k == 3)) n++;
            end
            if (n > 7) n = 7;
            if (t < 4 * d) begin
                vec = t / d;
                chk({tag, ".busy"}, 32'(busy), 1);
                chk({tag, ".done"}, 32'(done), 0);
                chk({tag, ".vec_idx"}, 32'(vec_idx), 32'(vec));
                chk({tag, ".a"}, 32'(a), 32'(vec >> 1));
                chk({tag, ".b"}, 32'(b), 32'(vec & 1));
                chk({tag, ".err_cnt"}, 32'(err_cnt), 32'(n));
                chk({tag, ".pass"}, 32'(pass), 0);
            end else begin
                chk({tag, ".busy"}, 32'(busy), 0);
                chk({tag, ".done"}, 32'(done), 32'(t == 4 * d));
                chk({tag, ".vec_idx"}, 32'(vec_idx), 0);
                chk({tag, ".a"}, 32'(a), 0);
                chk({tag, ".b"}, 32'(b), 0);
                chk({tag, ".err_cnt"}, 32'(err_cnt), 32'(n));
                chk({tag, ".pass"}, 32'(pass), 32'(n == 0));
                if (chk1 && t == 4 * d) begin
                    chk({tag, ".err1_sat"}, 32'(err1), 1);
                    chk({tag, ".pass1"}, 32'(pass1), 0);
                    chk({tag, ".done1"}, 32'(done1), 1);
                end
            end
            if (t == 4 * d + 1) break;
            nxt = t + 1;
            if (nxt % d == 0 && nxt <= 4 * d) c = gate_out(mode, nxt / d - 1);
            else if (glitch) c = 1'($urandom);
            else c = gate_out(mode, (t / d > 3) ? 3 : t / d);
            start = extra_start && (t == d + 1 || t == 4 * d);
            if (nxt == abort_t) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                start = 1'b0;
                chk_zero({tag, ".abort"});
                tick();
                chk_zero({tag, ".abort_hold"});
                return;
            end
            tick();
        end
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b1;
        dwell = 8'd5;
        c = 1'b0;
        tick();
        chk_zero("reset1");
        tick();
        chk_zero("reset2");
        rst = 1'b0;
        start = 1'b0;
        tick();
        chk_zero("reset_idle");
        chk("reset_idle.busy1", 32'(busy1), 0);

        run("and_d3", 3, 0, 1'b0, -1, 1'b0, 1'b1);
        run("stuck0_d2", 2, 1, 1'b0, -1, 1'b0, 1'b1);
        run("stuck1_d2", 2, 2, 1'b0, -1, 1'b0, 1'b1);
        run("and_d0", 0, 0, 1'b0, -1, 1'b0, 1'b1);
        run("extra_start", 2, 0, 1'b0, -1, 1'b1, 1'b1);
        run("abort_v2", 3, 0, 1'b0, 7, 1'b0, 1'b0);
        run("after_abort", 3, 0, 1'b0, -1, 1'b0, 1'b1);
        run("nand_d1", 1, 3, 1'b0, -1, 1'b0, 1'b1);

        for (int r = 0; r < 10; r++) begin
            run("rand", int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                1'b1, -1, 1'b0, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gate_vector_sequencer.md
Name: gate_vector_sequencer

Overview:
Upstream stimulus-and-check stage for a 2-input primitive gate (AND). On `start`, it drives the four input combinations {a,b} = 00, 01, 10, 11 in order. Each vector is held for a programmable dwell time. On the last cycle of each dwell, it samples the gate output `c` and compares it with the expected a&b. It then reports an error count and a pass/fail result, turning the open-loop bench into a self-checking one.

Parameters:
DWELL_W, 8, width of the dwell-time input (cycles per vector).
ERR_W, 3, width of the saturating mismatch counter.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  synchronous, active-high reset.
start  input  1  run request; honoured only in IDLE.
dwell  input  DWELL_W  cycles each vector is held; latched at start; 0 is treated as 1.
c  input  1  gate output under test.
a  output  1  gate input a (registered).
b  output  1  gate input b (registered).
vec_idx  output  2  index of the vector currently applied; {a,b} == vec_idx during RUN.
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse when the run completes.
pass  output  1  1 if the last completed run had zero mismatches; held until the next start.
err_cnt  output  ERR_W  mismatches in the current or last run; saturates at all-ones.

Behaviour:
- Reset (synchronous, at a clk edge with rst=1):
  - All outputs go to 0: a, b, vec_idx, busy, done, pass, err_cnt.
  - FSM goes to IDLE; the internal dwell counter cnt goes to 0.
  - rst has priority over every other input.
- Reset mid-run aborts the run: no done pulse, and pass stays 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - a, b and vec_idx are 0; busy=0.
  - On an edge with start=1:
    - latch D = (dwell==0) ? 1 : dwell;
    - clear err_cnt, pass, vec_idx and cnt;
    - set busy=1; go to RUN.
- RUN, at each edge:
  - If cnt == D-1 (sample edge):
    - compare c against (a&b); on mismatch, err_cnt increments unless already all-ones;
    - if vec_idx == 3: go to DONE, set a=b=0, vec_idx=0, busy=0, done=1, pass = (final err_cnt == 0), with the last sample's result included;
    - else: vec_idx increments, {a,b} takes the new vec_idx, cnt=0.
  - Else: cnt increments.
- DONE:
  - Lasts exactly one cycle with done=1; the next edge returns to IDLE with done=0.
  - start is ignored in DONE.
- Timing, with start sampled at edge E0:
  - vector k is applied in cycles E0+kD+1 through E0+(k+1)D;
  - c is sampled at edge E0+(k+1)D;
  - done is high during the cycle after edge E0+4D;
  - total run length is 4D cycles.
- start while busy or in DONE is ignored; dwell changes after the latch have no effect.
- c is sampled only at sample edges; glitches on c at other times have no effect.
- err_cnt and pass hold their values in IDLE until the next accepted start.
- Outputs a, b, vec_idx, busy, done, pass and err_cnt are all registered; no combinational path from inputs to outputs.

Test Plan:
1. Reset: assert rst for 2 cycles with start=1 -> a=b=0, busy=0, done=0, pass=0, err_cnt=0, FSM stays IDLE.
2. Correct AND gate, dwell=3, start pulse -> {a,b} goes 00, 01, 10, 11, each held 3 cycles; done pulses once in cycle 13 after start; err_cnt=0, pass=1; a=b=0 afterwards.
3. Stuck-at faults, dwell=2:
   - c tied 0 -> err_cnt=1 (only vector 11 fails), pass=0;
   - c tied 1 -> err_cnt=3, pass=0.
4. dwell=0 -> treated as 1: each vector lasts 1 cycle, done in cycle 5 after start, pass=1 with a correct gate.
5. start pulsed at vector 1 and again during DONE -> ignored; exactly one done pulse. Then rst asserted during vector 2 of a fresh run -> all outputs 0 next cycle, no done pulse; a following start runs cleanly to pass=1.
6. ERR_W=1 and c = ~(a&b) -> 4 mismatches; err_cnt saturates at 1, pass=0.
